// File: rtl/switch_allocator_if.sv
// switch_allocator_if: request, crossbar-feedback and result bundle of the switch allocator
// master: the pipeline around the allocator (drives sa_*, flit/tail/credit events)
// slave : the allocator (drives pipe_* result and switch_* crossbar control)
interface switch_allocator_if #(
    parameter int NUM_BUFFERS  = 4,
    parameter int NUM_OUTPORTS = 4,
    parameter int NUM_VCS      = 2
);
    localparam int IW = $clog2(NUM_BUFFERS) + (NUM_BUFFERS == 1);
    localparam int EW = $clog2(NUM_OUTPORTS) + (NUM_OUTPORTS == 1);
    localparam int VW = $clog2(NUM_VCS);
    logic                            sa_valid;
    logic [IW-1:0]                   sa_ingress_port;
    logic [EW-1:0]                   sa_egress_port;
    logic [VW-1:0]                   sa_final_vc;
    logic [NUM_OUTPORTS-1:0]         flit_sent;
    logic [NUM_OUTPORTS-1:0]         tail_sent;
    logic [NUM_OUTPORTS*NUM_VCS-1:0] credit_return;
    logic                            pipe_valid;
    logic [IW-1:0]                   pipe_ingress_port;
    logic                            pipe_failed;
    logic [NUM_OUTPORTS-1:0]         switch_en;
    logic [NUM_OUTPORTS*IW-1:0]      switch_sel;
    logic [NUM_OUTPORTS*VW-1:0]      switch_vc;
    modport master (
        output sa_valid, sa_ingress_port, sa_egress_port, sa_final_vc,
        output flit_sent, tail_sent, credit_return,
        input  pipe_valid, pipe_ingress_port, pipe_failed,
        input  switch_en, switch_sel, switch_vc
    );
    modport slave (
        input  sa_valid, sa_ingress_port, sa_egress_port, sa_final_vc,
        input  flit_sent, tail_sent, credit_return,
        output pipe_valid, pipe_ingress_port, pipe_failed,
        output switch_en, switch_sel, switch_vc
    );
endinterface

// File: rtl/switch_allocator.sv
// switch_allocator: per-egress ownership FSM plus per-(egress,vc) credit check, 1-cycle grant/deny
// Ports: clk, rst (sync, active-high); bus = switch_allocator_if.slave carrying the
// sa_* request, flit/tail/credit feedback, pipe_* result and switch_* crossbar control.
// Optional: SA_RELEASE_BYPASS_EN lets a request take an egress whose tail leaves this cycle.
module switch_allocator #(
    parameter int NUM_BUFFERS  = 4,
    parameter int NUM_OUTPORTS = 4,
    parameter int NUM_VCS      = 2,
    parameter int BUFFER_DEPTH = 8
) (
    input logic             clk,
    input logic             rst,
    switch_allocator_if.slave bus
);
    localparam int IW = $clog2(NUM_BUFFERS) + (NUM_BUFFERS == 1);
    localparam int EW = $clog2(NUM_OUTPORTS) + (NUM_OUTPORTS == 1);
    localparam int VW = $clog2(NUM_VCS);
    localparam int CW = $clog2(BUFFER_DEPTH + 1);
    typedef enum logic {FREE, OWNED} state_t;
    state_t                                st [NUM_OUTPORTS];
    logic [CW-1:0]                         credit [NUM_OUTPORTS][NUM_VCS];
    logic [NUM_OUTPORTS-1:0][IW-1:0]       sel;
    logic [NUM_OUTPORTS-1:0][VW-1:0]       vcs;
    logic [NUM_OUTPORTS-1:0][NUM_VCS-1:0]  inc, dec;
    logic                                  eg_ok, vc_ok, free, grant;
    logic [EW-1:0]                         eg;
    logic [VW-1:0]                         vc;
    // Out-of-range indices are clamped to 0 so lookups stay in bounds; the *_ok flags deny them.
    always_comb begin
        eg_ok = {1'b0, bus.sa_egress_port} < (EW+1)'(NUM_OUTPORTS);
        vc_ok = {1'b0, bus.sa_final_vc} < (VW+1)'(NUM_VCS);
        eg = eg_ok ? bus.sa_egress_port : '0;
        vc = vc_ok ? bus.sa_final_vc : '0;
`ifdef SA_RELEASE_BYPASS_EN
        free = st[eg] == FREE || bus.tail_sent[eg];
`else
        free = st[eg] == FREE;
`endif
        // Credit is judged on the registered (pre-decrement) value.
        grant = bus.sa_valid && eg_ok && vc_ok && free && credit[eg][vc] != '0;
        for (int e = 0; e < NUM_OUTPORTS; e++) begin
            bus.switch_en[e] = st[e] == OWNED;
            for (int v = 0; v < NUM_VCS; v++) begin
                dec[e][v] = bus.flit_sent[e] && st[e] == OWNED && vcs[e] == VW'(v);
                inc[e][v] = bus.credit_return[e*NUM_VCS+v];
            end
        end
    end
    assign bus.switch_sel = sel;
    assign bus.switch_vc  = vcs;
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.pipe_valid        <= 1'b0;
            bus.pipe_failed       <= 1'b0;
            bus.pipe_ingress_port <= '0;
            for (int e = 0; e < NUM_OUTPORTS; e++) begin
                st[e]  <= FREE;
                sel[e] <= '0;
                vcs[e] <= '0;
                for (int v = 0; v < NUM_VCS; v++)
                    credit[e][v] <= CW'(BUFFER_DEPTH);
            end
        end else begin
            bus.pipe_valid  <= bus.sa_valid;
            bus.pipe_failed <= bus.sa_valid && !grant;
            if (bus.sa_valid)
                bus.pipe_ingress_port <= bus.sa_ingress_port;
            for (int e = 0; e < NUM_OUTPORTS; e++) begin
                // Grant is written last so a bypassed release keeps the egress OWNED.
                if (st[e] == OWNED && bus.tail_sent[e])
                    st[e] <= FREE;
                if (grant && eg == EW'(e)) begin
                    st[e]  <= OWNED;
                    sel[e] <= bus.sa_ingress_port;
                    vcs[e] <= vc;
                end
                for (int v = 0; v < NUM_VCS; v++) begin
                    if (inc[e][v] && !dec[e][v] && credit[e][v] != CW'(BUFFER_DEPTH))
                        credit[e][v] <= credit[e][v] + CW'(1);
                    else if (dec[e][v] && !inc[e][v] && credit[e][v] != '0)
                        credit[e][v] <= credit[e][v] - CW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_switch_allocator.sv
// tb_switch_allocator: directed vector table, credit corner sequence and randomized model check
module tb_switch_allocator;
    localparam int NB = 4, NO = 5, NV = 2, BD = 8;
`ifdef SA_RELEASE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    always #5 clk = ~clk;
    switch_allocator_if #(.NUM_BUFFERS(NB), .NUM_OUTPORTS(NO), .NUM_VCS(NV)) bus ();
    switch_allocator #(.NUM_BUFFERS(NB), .NUM_OUTPORTS(NO), .NUM_VCS(NV), .BUFFER_DEPTH(BD)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
    typedef struct {
        bit         r, sv;
        logic [1:0] ing;
        logic [2:0] eg;
        logic       vc;
        logic [4:0] fs, ts;
        logic [9:0] cr;
        bit         pv, pf;
        logic [1:0] pi;
        logic [4:0] en;
        logic [9:0] sel;
        logic [4:0] svc;
        int         c00;
    } vec_t;
    vec_t tbl[$];
    function automatic vec_t mk(bit r, bit sv, logic [1:0] ing, logic [2:0] eg, logic vc,
                                logic [4:0] fs, logic [4:0] ts, logic [9:0] cr, bit pv, bit pf,
                                logic [1:0] pi, logic [4:0] en, logic [9:0] sel, logic [4:0] svc, int c00);
        vec_t t;
        t.r = r; t.sv = sv; t.ing = ing; t.eg = eg; t.vc = vc; t.fs = fs; t.ts = ts; t.cr = cr;
        t.pv = pv; t.pf = pf; t.pi = pi; t.en = en; t.sel = sel; t.svc = svc; t.c00 = c00;
        return t;
    endfunction
    task automatic chk(string n, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", n, act, exp);
        end
    endtask
    task automatic step(bit r, bit sv, logic [1:0] ing, logic [2:0] eg, logic vc,
                        logic [4:0] fs, logic [4:0] ts, logic [9:0] cr);
        rst = r;
        bus.sa_valid = sv;
        bus.sa_ingress_port = ing;
        bus.sa_egress_port = eg;
        bus.sa_final_vc = vc;
        bus.flit_sent = fs;
        bus.tail_sent = ts;
        bus.credit_return = cr;
        @(posedge clk);
        #1;
    endtask
    // Reference model: ownership flags, owner records and integer credit counts.
    bit         m_own [NO];
    logic [1:0] m_sel [NO];
    logic       m_vc  [NO];
    int         m_cred [NO][NV];
    bit         m_pv, m_pf;
    logic [1:0] m_pi;
    task automatic model(bit r, bit sv, logic [1:0] ing, logic [2:0] eg, logic vc,
                         logic [4:0] fs, logic [4:0] ts, logic [9:0] cr);
        bit g;
        int c;
        if (r) begin
            m_pv = 0; m_pf = 0; m_pi = 0;
            for (int e = 0; e < NO; e++) begin
                m_own[e] = 0; m_sel[e] = 0; m_vc[e] = 0;
                for (int v = 0; v < NV; v++) m_cred[e][v] = BD;
            end
            return;
        end
        g = 0;
        if (sv && int'(eg) < NO)
            g = (!m_own[eg] || (BYP && ts[eg])) && m_cred[eg][vc] > 0;
        m_pv = sv;
        m_pf = sv && !g;
        if (sv) m_pi = ing;
        for (int e = 0; e < NO; e++) begin
            for (int v = 0; v < NV; v++) begin
                c = m_cred[e][v] + int'(cr[e*NV+v]) - int'(fs[e] && m_own[e] && int'(m_vc[e]) == v);
                m_cred[e][v] = c < 0 ? 0 : (c > BD ? BD : c);
            end
            m_own[e] = (m_own[e] && !ts[e]) || (g && int'(eg) == e);
            if (g && int'(eg) == e) begin
                m_sel[e] = ing;
                m_vc[e] = vc;
            end
        end
    endtask
    initial begin
        logic [4:0] en_b, vc_b, vc_x, en_x;
        logic [9:0] sel_b, sel_x;
        bit r, sv;
        logic [1:0] ing;
        logic [2:0] eg;
        logic vc;
        logic [4:0] fs, ts;
        logic [9:0] cr;
        // Expected outputs that differ with the release bypass.
        en_b  = BYP ? 5'b00110 : 5'b00010;
        sel_b = BYP ? 10'h02C : 10'h01C;
        vc_b  = BYP ? 5'b00110 : 5'b00010;
        tbl.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 10'h000, 5'b00000, 8));
        tbl.push_back(mk(0, 1, 2, 1, 0, 0, 0, 0, 1, 0, 2, 5'b00010, 10'h008, 5'b00000, 8));
        tbl.push_back(mk(0, 1, 3, 1, 1, 0, 0, 0, 1, 1, 3, 5'b00010, 10'h008, 5'b00000, 8));
        tbl.push_back(mk(0, 0, 3, 1, 1, 0, 5'b00010, 0, 0, 0, 3, 5'b00000, 10'h008, 5'b00000, 8));
        tbl.push_back(mk(0, 1, 3, 1, 1, 0, 0, 0, 1, 0, 3, 5'b00010, 10'h00C, 5'b00010, 8));
        tbl.push_back(mk(0, 1, 0, 5, 0, 0, 0, 0, 1, 1, 0, 5'b00010, 10'h00C, 5'b00010, 8));
        tbl.push_back(mk(0, 1, 1, 7, 1, 0, 0, 0, 1, 1, 1, 5'b00010, 10'h00C, 5'b00010, 8));
        tbl.push_back(mk(0, 1, 1, 2, 0, 0, 0, 0, 1, 0, 1, 5'b00110, 10'h01C, 5'b00010, 8));
        tbl.push_back(mk(0, 1, 2, 2, 1, 0, 5'b00100, 0, 1, !BYP, 2, en_b, sel_b, vc_b, 8));
        en_x = en_b | 5'b10000;
        vc_x = vc_b | 5'b10000;
        tbl.push_back(mk(0, 1, 0, 4, 1, 0, 0, 0, 1, 0, 0, en_x, sel_b, vc_x, 8));
        en_x = en_x | 5'b00001;
        sel_x = sel_b | 10'h001;
        tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 1, 0, 1, en_x, sel_x, vc_x, 8));
        for (int k = 0; k < 5; k++)
            tbl.push_back(mk(0, 0, 1, 0, 0, 5'b00001, 0, 0, 0, 0, 1, en_x, sel_x, vc_x, 7 - k));
        tbl.push_back(mk(1, 1, 3, 3, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 10'h000, 5'b00000, 8));
        tbl.push_back(mk(0, 0, 0, 0, 0, 5'b00001, 0, 0, 0, 0, 0, 5'b00000, 10'h000, 5'b00000, 8));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 10'h001, 0, 0, 0, 5'b00000, 10'h000, 5'b00000, 8));
        foreach (tbl[i]) begin
            step(tbl[i].r, tbl[i].sv, tbl[i].ing, tbl[i].eg, tbl[i].vc, tbl[i].fs, tbl[i].ts, tbl[i].cr);
            chk($sformatf("row%0d pipe_valid", i), bus.pipe_valid, tbl[i].pv);
            chk($sformatf("row%0d pipe_failed", i), bus.pipe_failed, tbl[i].pf);
            chk($sformatf("row%0d pipe_ingress_port", i), bus.pipe_ingress_port, tbl[i].pi);
            chk($sformatf("row%0d switch_en", i), bus.switch_en, tbl[i].en);
            chk($sformatf("row%0d switch_sel", i), bus.switch_sel, tbl[i].sel);
            chk($sformatf("row%0d switch_vc", i), bus.switch_vc, tbl[i].svc);
            chk($sformatf("row%0d credit00", i), dut.credit[0][0], tbl[i].c00);
        end
        // Credit exhaustion on eg0/vc1, underflow guard, then a single return re-enables grants.
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 1, 0, 0, 0);
        chk("exh grant", bus.pipe_failed, 0);
        for (int k = 0; k < 9; k++) step(0, 0, 0, 0, 0, 5'b00001, 0, 0);
        chk("exh credit0", dut.credit[0][1], 0);
        step(0, 0, 0, 0, 0, 0, 5'b00001, 0);
        chk("exh released", bus.switch_en[0], 0);
        step(0, 1, 1, 0, 1, 0, 0, 0);
        chk("exh denied", bus.pipe_failed, 1);
        chk("exh denied en", bus.switch_en[0], 0);
        step(0, 0, 0, 0, 0, 0, 0, 10'h002);
        chk("exh credit1", dut.credit[0][1], 1);
        step(0, 1, 1, 0, 1, 0, 0, 0);
        chk("exh regrant", bus.pipe_failed, 0);
        chk("exh regrant en", bus.switch_en[0], 1);
        chk("exh regrant sel", bus.switch_sel[1:0], 1);
        // Randomized run against the reference model.
        for (int n = 0; n < 3000; n++) begin
            r = (n == 0) || ($urandom_range(99) == 0);
            sv = $urandom_range(3) != 0;
            ing = 2'($urandom_range(3));
            eg = ($urandom_range(9) == 0) ? 3'($urandom_range(7, 5)) : 3'($urandom_range(4));
            vc = 1'($urandom_range(1));
            fs = 5'($urandom);
            ts = 0;
            cr = 0;
            for (int e = 0; e < NO; e++) ts[e] = $urandom_range(5) == 0;
            for (int j = 0; j < NO*NV; j++) cr[j] = $urandom_range(2) == 0;
            model(r, sv, ing, eg, vc, fs, ts, cr);
            step(r, sv, ing, eg, vc, fs, ts, cr);
            for (int e = 0; e < NO; e++) begin
                en_x[e] = m_own[e];
                vc_x[e] = m_vc[e];
                sel_x[e*2 +: 2] = m_sel[e];
            end
            chk($sformatf("rnd%0d pipe_valid", n), bus.pipe_valid, m_pv);
            chk($sformatf("rnd%0d pipe_failed", n), bus.pipe_failed, m_pf);
            chk($sformatf("rnd%0d pipe_ingress_port", n), bus.pipe_ingress_port, m_pi);
            chk($sformatf("rnd%0d switch_en", n), bus.switch_en, en_x);
            chk($sformatf("rnd%0d switch_sel", n), bus.switch_sel, sel_x);
            chk($sformatf("rnd%0d switch_vc", n), bus.switch_vc, vc_x);
            for (int e = 0; e < NO; e++)
                for (int v = 0; v < NV; v++)
                    chk($sformatf("rnd%0d credit%0d%0d", n, e, v), dut.credit[e][v], m_cred[e][v]);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
